ahbl_sram_slave: RTL and testbench

- AHB-Lite responder (slave) that terminates one splitter output port and fronts a single-port synchronous SRAM.
- Decodes address-phase signals and generates byte-lane strobes from HSIZE/HADDR.
- Inserts a configurable number of wait states and returns OKAY or a two-cycle ERROR response.
- Instantiated once per memory region behind the bus splitter; its HSEL/HREADYOUT/HRDATA connect to one splitter slave port.

---
 rtl/ahbl_sram_slave.sv | 130 +++++++++++++
 tb/tb_ahbl_sram_slave.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder fronting a single-port synchronous SRAM.
// Adds WAIT_STATES data-phase wait cycles and returns a two-cycle ERROR response for illegal size/alignment.
module ahbl_sram_slave #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic          HREADY,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [3:0]    sram_wben,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WR,
        RD_ISSUE,
        RD_DATA,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t        state, state_nxt;
    logic [1:0]    wait_cnt, wait_cnt_nxt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [31:0]   rdata_q;
    logic [3:0]    lanes;
    logic          accept;
    logic          addr_err;
    logic          unused_addr_bits;

    // Decode splitter ignores these bits; the upper address is already resolved.
    assign unused_addr_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    // A new transfer can only be taken while this slave is not stalling the bus.
    assign accept   = HSEL & HTRANS[1] & HREADY & HREADYOUT;
    assign addr_err = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE, WR, RD_DATA, ERR2: begin
                state_nxt = IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = ERR1;
                    end else if (WAIT_STATES != 0) begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end else begin
                        state_nxt = HWRITE ? WR : RD_ISSUE;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 2'd0) begin
                    state_nxt = write_q ? WR : RD_ISSUE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 2'd1;
                end
            end
            RD_ISSUE: state_nxt = RD_DATA;
            ERR1:     state_nxt = ERR2;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            rdata_q  <= 32'h0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                addr_q  <= HADDR[AW+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
            if (state == RD_DATA) begin
                rdata_q <= sram_rdata;
            end
        end
    end

    always_comb begin
        lanes = 4'b1111;
        case (size_q)
            3'd0:    lanes = 4'b0001 << addr_q[1:0];
            3'd1:    lanes = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // Read data bypasses the holding register in the completing cycle.
    assign HREADYOUT  = (state == IDLE) || (state == WR) || (state == RD_DATA) || (state == ERR2);
    assign HRESP      = (state == ERR1) || (state == ERR2);
    assign HRDATA     = (state == RD_DATA) ? sram_rdata : rdata_q;
    assign sram_ce    = (state == WR) || (state == RD_ISSUE);
    assign sram_we    = (state == WR);
    assign sram_wben  = (state == WR) ? lanes : 4'b0000;
    assign sram_addr  = addr_q[AW+1:2];
    assign sram_wdata = HWDATA;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave: three instances (0, 2 and 3 wait states) share one AHB master.
// Read results are scoreboarded at address phase and compared when the data phase completes.
module tb_ahbl_sram_slave;

    typedef struct packed {
        logic        wr;
        logic        err;
        logic [31:0] data;
    } sb_entry_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL_bus;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;

    logic        hsel        [3];
    logic        hready_out  [3];
    logic        hresp       [3];
    logic [31:0] hrdata      [3];
    logic        sram_ce     [3];
    logic        sram_we     [3];
    logic [3:0]  sram_wben   [3];
    logic [9:0]  sram_addr   [3];
    logic [31:0] sram_wdata  [3];
    logic [31:0] sram_rdata  [3];
    logic [31:0] mem         [3][1024];

    int          active;
    int          checks = 0;
    int          errors = 0;
    int          ce_cnt [3];
    logic        last_we    [3];
    logic [3:0]  last_wben  [3];
    logic [9:0]  last_addr  [3];
    logic [31:0] last_wdata [3];
    logic        last_rdy   [3];

    sb_entry_t   sb_q [$];
    logic        dp_valid;
    logic        dp_err;
    logic [31:0] dp_wdata;
    int          last_stalls;
    int          base;

    always #5 HCLK = ~HCLK;

    assign HREADY = hready_out[active];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        assign hsel[g] = HSEL_bus && (active == g);
        ahbl_sram_slave #(.AW(10), .WAIT_STATES(WS)) dut (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .HSEL      (hsel[g]),
            .HADDR     (HADDR),
            .HTRANS    (HTRANS),
            .HWRITE    (HWRITE),
            .HSIZE     (HSIZE),
            .HREADY    (HREADY),
            .HWDATA    (HWDATA),
            .HREADYOUT (hready_out[g]),
            .HRESP     (hresp[g]),
            .HRDATA    (hrdata[g]),
            .sram_ce   (sram_ce[g]),
            .sram_we   (sram_we[g]),
            .sram_wben (sram_wben[g]),
            .sram_addr (sram_addr[g]),
            .sram_wdata(sram_wdata[g]),
            .sram_rdata(sram_rdata[g])
        );
    end

    // Behavioural SRAM per instance: byte-lane writes, one-cycle read latency.
    always @(posedge HCLK) begin
        for (int k = 0; k < 3; k++) begin
            if (sram_ce[k] === 1'b1) begin
                if (sram_we[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sram_wben[k][b]) mem[k][sram_addr[k]][8*b +: 8] <= sram_wdata[k][8*b +: 8];
                    end
                end else begin
                    sram_rdata[k] <= mem[k][sram_addr[k]];
                end
            end
        end
    end

    always @(negedge HCLK) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (sram_ce[k] === 1'b1) begin
                ce_cnt[k]++;
                last_we[k]    = sram_we[k];
                last_wben[k]  = sram_wben[k];
                last_addr[k]  = sram_addr[k];
                last_wdata[k] = sram_wdata[k];
                last_rdy[k]   = hready_out[k];
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One address phase; also carries the data phase of the previous transfer to completion.
    task automatic apply_stimulus(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                  input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                                  input logic exp_err, input logic [31:0] exp_rdata);
        int        stalls;
        bit        done;
        sb_entry_t e;
        HSEL_bus = sel;
        HTRANS   = trans;
        HADDR    = addr;
        HWRITE   = wr;
        HSIZE    = size;
        HWDATA   = dp_wdata;
        stalls   = 0;
        done     = 0;
        if (!dp_valid) begin
            check_output("idle_ready", 32'(HREADY), 32'd1);
            check_output("idle_resp", 32'(hresp[active]), 32'd0);
        end
        for (int c = 0; c < 16 && !done; c++) begin
            if (HREADY === 1'b1) begin
                done = 1;
                if (dp_valid) begin
                    e = sb_q.pop_front();
                    check_output("final_resp", 32'(hresp[active]), 32'(e.err));
                    if (!e.wr && !e.err) check_output("read_data", hrdata[active], e.data);
                end
            end else begin
                stalls++;
                check_output("stall_resp", 32'(hresp[active]), 32'(dp_err));
            end
            @(negedge HCLK);
        end
        if (!done) check_output("ready_timeout", 32'd0, 32'd1);
        last_stalls = stalls;
        if (sel && trans[1]) begin
            dp_valid = 1'b1;
            dp_err   = exp_err;
            dp_wdata = wdata;
            sb_q.push_back('{wr, exp_err, exp_rdata});
        end else begin
            dp_valid = 1'b0;
        end
    endtask

    task automatic bus_idle();
        apply_stimulus(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data, input logic err);
        apply_stimulus(1'b1, 2'b10, addr, 1'b1, size, data, err, 32'h0);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data, input logic err);
        apply_stimulus(1'b1, 2'b10, addr, 1'b0, size, 32'h0, err, data);
    endtask

    initial begin
        HRESETn  = 1'b0;
        HSEL_bus = 1'b0;
        HTRANS   = 2'b00;
        HADDR    = 32'h0;
        HWRITE   = 1'b0;
        HSIZE    = 3'd0;
        HWDATA   = 32'h0;
        active   = 0;
        dp_valid = 1'b0;
        dp_err   = 1'b0;
        dp_wdata = 32'h0;
        repeat (3) @(negedge HCLK);
        check_output("rst_readyout", 32'(hready_out[0]), 32'd1);
        check_output("rst_resp", 32'(hresp[0]), 32'd0);
        check_output("rst_rdata", hrdata[0], 32'h0);
        check_output("rst_ce", 32'(sram_ce[0]), 32'd0);
        check_output("rst_wben", 32'(sram_wben[0]), 32'd0);
        HRESETn = 1'b1;

        // Zero wait states: word write then word read.
        base = ce_cnt[0];
        bus_write(32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
        bus_idle();
        check_output("wr_stalls", 32'(last_stalls), 32'd0);
        check_output("wr_ce_count", 32'(ce_cnt[0] - base), 32'd1);
        check_output("wr_we", 32'(last_we[0]), 32'd1);
        check_output("wr_wben", 32'(last_wben[0]), 32'hF);
        check_output("wr_addr", 32'(last_addr[0]), 32'd4);
        check_output("wr_wdata", last_wdata[0], 32'hDEADBEEF);
        check_output("wr_ready_at_ce", 32'(last_rdy[0]), 32'd1);
        bus_read(32'h10, 3'd2, 32'hDEADBEEF, 1'b0);
        bus_idle();
        check_output("rd_stalls", 32'(last_stalls), 32'd1);
        check_output("rd_ce_count", 32'(ce_cnt[0] - base), 32'd2);

        // Sub-word writes, pipelined into a read.
        bus_write(32'h13, 3'd0, 32'hAA000000, 1'b0);
        bus_write(32'h12, 3'd1, 32'h55550000, 1'b0);
        check_output("byte_wben", 32'(last_wben[0]), 32'h8);
        check_output("byte_wdata", last_wdata[0], 32'hAA000000);
        bus_read(32'h10, 3'd2, 32'h5555BEEF, 1'b0);
        check_output("half_wben", 32'(last_wben[0]), 32'hC);
        bus_idle();

        // Illegal size/alignment: two-cycle ERROR, no SRAM access.
        base = ce_cnt[0];
        bus_read(32'h02, 3'd2, 32'h0, 1'b1);
        bus_read(32'h10, 3'd3, 32'h0, 1'b1);
        check_output("err_stalls", 32'(last_stalls), 32'd1);
        bus_write(32'h11, 3'd1, 32'h0, 1'b1);
        bus_read(32'h10, 3'd2, 32'h5555BEEF, 1'b0);
        bus_idle();
        check_output("err_ce_count", 32'(ce_cnt[0] - base), 32'd1);

        // Pipelined traffic with IDLE and deselected cycles between.
        base = ce_cnt[0];
        bus_write(32'h20, 3'd2, 32'h12345678, 1'b0);
        apply_stimulus(1'b1, 2'b00, 32'h20, 1'b1, 3'd2, 32'h0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 2'b10, 32'h20, 1'b1, 3'd2, 32'h0, 1'b0, 32'h0);
        bus_write(32'h21, 3'd0, 32'h0000EF00, 1'b0);
        bus_read(32'h20, 3'd2, 32'h1234EF78, 1'b0);
        check_output("lane1_wben", 32'(last_wben[0]), 32'h2);
        bus_idle();
        check_output("pipe_ce_count", 32'(ce_cnt[0] - base), 32'd3);

        // Two wait states.
        active = 1;
        base   = ce_cnt[1];
        bus_write(32'h40, 3'd2, 32'hCAFEF00D, 1'b0);
        bus_idle();
        check_output("ws2_wr_stalls", 32'(last_stalls), 32'd2);
        check_output("ws2_wr_ce_count", 32'(ce_cnt[1] - base), 32'd1);
        check_output("ws2_wr_ready_at_ce", 32'(last_rdy[1]), 32'd1);
        check_output("ws2_wr_addr", 32'(last_addr[1]), 32'h10);
        bus_read(32'h40, 3'd2, 32'hCAFEF00D, 1'b0);
        bus_idle();
        check_output("ws2_rd_stalls", 32'(last_stalls), 32'd3);
        check_output("ws2_rd_ce_count", 32'(ce_cnt[1] - base), 32'd2);

        // Three wait states, then reset in the middle of a write.
        active = 2;
        bus_write(32'h08, 3'd2, 32'h0BADF00D, 1'b0);
        bus_read(32'h08, 3'd2, 32'h0BADF00D, 1'b0);
        check_output("ws3_wr_stalls", 32'(last_stalls), 32'd3);
        bus_idle();
        check_output("ws3_rd_stalls", 32'(last_stalls), 32'd4);
        check_output("ws3_rdata_hold", hrdata[2], 32'h0BADF00D);
        base = ce_cnt[2];
        bus_write(32'h08, 3'd2, 32'h11111111, 1'b0);
        HSEL_bus = 1'b0;
        HTRANS   = 2'b00;
        @(negedge HCLK);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check_output("mid_rst_readyout", 32'(hready_out[2]), 32'd1);
        check_output("mid_rst_resp", 32'(hresp[2]), 32'd0);
        check_output("mid_rst_rdata", hrdata[2], 32'h0);
        HRESETn  = 1'b1;
        dp_valid = 1'b0;
        sb_q.delete();
        repeat (5) @(negedge HCLK);
        check_output("mid_rst_no_ce", 32'(ce_cnt[2] - base), 32'd0);
        bus_read(32'h08, 3'd2, 32'h0BADF00D, 1'b0);
        bus_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
